// File: rtl/spram_pipe.sv
// Single-port SRAM with byte enables, 1..4 cycle read latency and a
// credit-limited valid/ready request/response interface.
module spram_pipe #(
  parameter int D_WIDTH   = 32,
  parameter int A_WIDTH   = 4,
  parameter int MEM_DEPTH = 2**A_WIDTH,
  parameter int RD_LAT    = 1,
  parameter int BE_WIDTH  = D_WIDTH/8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [A_WIDTH-1:0]  req_addr,
  input  logic [D_WIDTH-1:0]  req_wdata,
  input  logic [BE_WIDTH-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [D_WIDTH-1:0]  rsp_rdata,
  output logic                rsp_err
);

  localparam int OUT_DEPTH = RD_LAT + 2;
  localparam int PW        = $clog2(OUT_DEPTH);
  localparam int CW        = $clog2(OUT_DEPTH + 1);

  generate
    if (RD_LAT < 1 || RD_LAT > 4 || (D_WIDTH % 8) != 0 || D_WIDTH < 8 ||
        BE_WIDTH != D_WIDTH/8 || MEM_DEPTH < 1 || MEM_DEPTH > 2**A_WIDTH) begin : g_bad_params
      $error("spram_pipe: illegal parameter combination");
    end
  endgenerate

  logic [D_WIDTH-1:0] mem [MEM_DEPTH];
  logic               ready_en;
  logic [CW-1:0]      outstanding;
  logic               in_range;
  logic               accept;
  logic               rd_acc;
  logic               wr_acc;
  logic               pop;
  logic               push;
  logic [D_WIDTH-1:0] rd_word;

  logic               pipe_vld  [RD_LAT];
  logic [D_WIDTH-1:0] pipe_data [RD_LAT];
  logic               pipe_err  [RD_LAT];

  logic [D_WIDTH-1:0] fifo_data [OUT_DEPTH];
  logic               fifo_err  [OUT_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses only registered state so req_ready never depends on rsp_ready.
  assign req_ready = ready_en && (outstanding < CW'(OUT_DEPTH));
  assign in_range  = int'(req_addr) < MEM_DEPTH;
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_wr;
  assign wr_acc    = accept && req_wr;
  assign rd_word   = in_range ? mem[req_addr] : '0;

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pipe_vld[RD_LAT-1];
  assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem[w] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      outstanding <= '0;
    end else begin
      ready_en <= 1'b1;
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_data[i] <= '0;
        pipe_err[i]  <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= rd_acc;
      pipe_data[0] <= rd_word;
      pipe_err[0]  <= rd_acc && !in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
        pipe_err[i]  <= pipe_err[i-1];
      end
    end
  end

  // Never overflows: FIFO entries plus in-flight reads equal outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pipe_data[RD_LAT-1];
        fifo_err[wr_ptr]  <= pipe_err[RD_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_pipe.sv
// Bench for spram_pipe (RD_LAT=3, MEM_DEPTH=12): directed literal checks plus
// random traffic compared every cycle against a queue-based reference model.
module tb_spram_pipe;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int LAT   = 3;
  localparam int OUT   = LAT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  spram_pipe #(.D_WIDTH(DW), .A_WIDTH(AW), .MEM_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: word array, queue of pending responses with the edge
  // number at which each may first be seen, and a read credit count.
  typedef struct {
    logic [DW-1:0] d;
    bit            e;
    int            at;
  } rsp_t;

  logic [DW-1:0] mm [16];
  rsp_t          q [$];
  int            outst;
  bit            ready_en;
  int            ecnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return ready_en && (outst < OUT);
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].at <= ecnt);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mm[i] = '0;
    q.delete();
    outst    = 0;
    ready_en = 0;
  endtask

  task automatic compare();
    chk("req_ready", req_ready, m_ready());
    chk("rsp_valid", rsp_valid, m_valid());
    if (m_valid()) begin
      chk("rsp_rdata", rsp_rdata, q[0].d);
      chk("rsp_err", rsp_err, q[0].e);
    end
  endtask

  // One clock: decide handshakes from pre-edge model state, advance model, check.
  task automatic tick();
    bit   acc, pop;
    rsp_t r;
    acc = rst_n && req_valid && m_ready();
    pop = rst_n && m_valid() && rsp_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      ecnt++;
      ready_en = 1;
      if (pop) begin
        void'(q.pop_front());
        outst--;
      end
      if (acc && req_wr && int'(req_addr) < DEPTH) begin
        for (int b = 0; b < 4; b++)
          if (req_be[b]) mm[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else if (acc && !req_wr) begin
        r.e  = !(int'(req_addr) < DEPTH);
        r.d  = r.e ? '0 : mm[req_addr];
        r.at = ecnt + LAT;
        q.push_back(r);
        outst++;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic send(input bit wr, input int addr, input logic [DW-1:0] wd, input logic [3:0] be);
    int n;
    bit ok;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_wdata = wd;
    req_be    = be;
    n  = 0;
    ok = 0;
    while (!ok && n < 50) begin
      ok = req_ready;
      tick();
      n++;
    end
    if (!ok) chk("accept_timeout", req_ready, 1);
    req_valid = 1'b0;
  endtask

  // Expects rsp_ready=1 so the captured response is popped on the last tick.
  task automatic wait_rsp(output logic [DW-1:0] d, output bit e, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    d = rsp_rdata;
    e = rsp_err;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bit            e;
    int            lat, n_acc, nv, first, last;

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    model_clear();
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", req_ready, 0);
    tick();
    chk("ready_after_release", req_ready, 1);

    // Full-word write then read back.
    rsp_ready = 1'b1;
    send(1, 3, 32'hDEADBEEF, 4'hF);
    send(0, 3, '0, 4'h0);
    wait_rsp(d, e, lat);
    chk("rd3_data", d, 32'hDEADBEEF);
    chk("rd3_err", e, 0);
    chk("rd_latency", lat, LAT);

    // Partial byte write clears bytes 0 and 2 only.
    send(1, 5, 32'hFFFFFFFF, 4'hF);
    send(1, 5, 32'h00000000, 4'b0101);
    send(1, 5, 32'h11111111, 4'b0000);
    send(0, 5, '0, 4'h0);
    wait_rsp(d, e, lat);
    chk("byte_en_data", d, 32'hFF00FF00);

    // Out-of-range write is dropped; read flags error.
    send(1, 13, 32'h00001234, 4'hF);
    send(0, 13, '0, 4'h0);
    wait_rsp(d, e, lat);
    chk("oor_data", d, 0);
    chk("oor_err", e, 1);
    send(0, 11, '0, 4'h0);
    wait_rsp(d, e, lat);
    chk("last_addr_err", e, 0);

    for (int i = 0; i < DEPTH; i++) send(1, i, 32'hA5000000 | i, 4'hF);

    // Credit limit: with responses stalled, exactly OUT reads are accepted.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    n_acc     = 0;
    repeat (12) begin
      req_addr = AW'($urandom_range(0, DEPTH - 1));
      if (req_ready) n_acc++;
      tick();
    end
    chk("credit_accepts", n_acc, 5);
    chk("credit_ready_low", req_ready, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("ready_after_first_pop", req_ready, 1);
    repeat (8) tick();

    // Back-to-back reads with rsp_ready held high.
    n_acc = 0; nv = 0; first = -1; last = -1;
    for (int t = 0; t < 12 + LAT + 3; t++) begin
      req_valid = (t < 12);
      req_wr    = 1'b0;
      req_addr  = AW'(t % 16);
      if (req_valid && req_ready) n_acc++;
      tick();
      if (rsp_valid) begin
        if (first < 0) first = t;
        last = t;
        nv++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 12);
    chk("b2b_responses", nv, 12);
    chk("b2b_first_rsp", first, LAT);
    chk("b2b_rsp_span", last - first, 11);

    // Reset in the middle of pending reads.
    rsp_ready = 1'b0;
    send(0, 1, '0, 4'h0);
    send(0, 2, '0, 4'h0);
    send(0, 4, '0, 4'h0);
    repeat (2) tick();
    chk("pre_reset_valid", rsp_valid, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_req_ready", req_ready, 0);
    repeat (2) tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    nv = 0;
    repeat (8) begin
      tick();
      if (rsp_valid) nv++;
    end
    chk("stale_rsp", nv, 0);
    send(0, 7, '0, 4'h0);
    wait_rsp(d, e, lat);
    chk("post_reset_data", d, 0);
    chk("post_reset_err", e, 0);

    // Random traffic against the model.
    repeat (400) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_wr    = $urandom_range(0, 1) == 1;
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    chk("drained", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
